// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers, border masking, FILL/RUN/FLUSH sequencing.
// Define CONV_WIN_REPLICATE_EN to clamp out-of-image taps to the nearest pixel instead of zero.
module conv_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [19:0]  i_data,
    output logic         o_valid,
    output logic [179:0] o_data,
    output logic         o_done
);

    // state | meaning
    // FILL  | accepting the first IMG_W+1 pixels, no windows yet
    // RUN   | each accepted pixel emits one window
    // FLUSH | IMG_W+1 virtual zero pixels drain the last windows, input stalled
    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d, ocol_q, ocol_d;
    logic [RW-1:0]   row_q, row_d, orow_q, orow_d;
    logic [8:0][19:0] win_q, win_d, win_sh, win_m;
    logic [179:0]    o_data_q, o_data_d;
    logic            o_valid_q, o_valid_d;
    logic            o_done_q, o_done_d;

    logic [19:0]     lb0_q [IMG_W];
    logic [19:0]     lb1_q [IMG_W];

    logic            accept, shift, emit, last_out;
    logic [19:0]     px, tap_top, tap_mid;

    always_comb begin
        accept   = i_valid && (state_q != S_FLUSH);
        shift    = accept || (state_q == S_FLUSH);
        emit     = (accept && (state_q == S_RUN)) || (state_q == S_FLUSH);
        px       = (state_q == S_FLUSH) ? 20'h00000 : i_data;
        tap_top  = lb1_q[col_q];
        tap_mid  = lb0_q[col_q];
        last_out = (ocol_q == COL_LAST) && (orow_q == ROW_LAST);
    end

    // Newest column enters at col offset 2; stale wrapped columns are removed by the mask below.
    always_comb begin
        win_sh = '0;
        for (int r = 0; r < 3; r++) begin
            win_sh[3*r]     = win_q[3*r+1];
            win_sh[3*r + 1] = win_q[3*r+2];
        end
        win_sh[2] = tap_top;
        win_sh[5] = tap_mid;
        win_sh[8] = px;
    end

    always_comb begin
        win_m = win_sh;
`ifdef CONV_WIN_REPLICATE_EN
        for (int c = 0; c < 3; c++) begin
            if (orow_q == '0)      win_m[c]     = win_m[3 + c];
            if (orow_q == ROW_LAST) win_m[6 + c] = win_m[3 + c];
        end
        for (int r = 0; r < 3; r++) begin
            if (ocol_q == '0)      win_m[3*r]     = win_m[3*r + 1];
            if (ocol_q == COL_LAST) win_m[3*r + 2] = win_m[3*r + 1];
        end
`else
        for (int c = 0; c < 3; c++) begin
            if (orow_q == '0)      win_m[c]     = 20'h00000;
            if (orow_q == ROW_LAST) win_m[6 + c] = 20'h00000;
        end
        for (int r = 0; r < 3; r++) begin
            if (ocol_q == '0)      win_m[3*r]     = 20'h00000;
            if (ocol_q == COL_LAST) win_m[3*r + 2] = 20'h00000;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        ocol_d    = ocol_q;
        orow_d    = orow_q;
        win_d     = win_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        o_done_d  = 1'b0;

        if (shift) begin
            win_d = win_sh;
            col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
        end
        if (accept && (col_q == COL_LAST) && (row_q != ROW_LAST)) begin
            row_d = row_q + RW'(1);
        end

        if (emit) begin
            o_valid_d = 1'b1;
            o_data_d  = win_m;
            o_done_d  = last_out;
            if (ocol_q == COL_LAST) begin
                ocol_d = '0;
                if (orow_q != ROW_LAST) orow_d = orow_q + RW'(1);
            end else begin
                ocol_d = ocol_q + CW'(1);
            end
        end

        case (state_q)
            S_FILL: begin
                if (accept && (row_q == RW'(1)) && (col_q == '0)) state_d = S_RUN;
            end
            S_RUN: begin
                if (accept && (col_q == COL_LAST) && (row_q == ROW_LAST)) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (last_out) begin
                    state_d = S_FILL;
                    col_d   = '0;
                    row_d   = '0;
                    ocol_d  = '0;
                    orow_d  = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FILL;
            col_q     <= '0;
            row_q     <= '0;
            ocol_q    <= '0;
            orow_q    <= '0;
            win_q     <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ocol_q    <= ocol_d;
            orow_q    <= orow_d;
            win_q     <= win_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_done_q  <= o_done_d;
        end
    end

    // Line buffers need no reset: unwritten rows are always masked.
    always_ff @(posedge clk) begin
        if (shift) begin
            lb1_q[col_q] <= tap_mid;
            lb0_q[col_q] <= px;
        end
    end

    assign i_ready = (state_q != S_FLUSH);
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_done  = o_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4 image; pixel value = raster index + 1.
module tb_conv_window_gen;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic         clk;
    logic         reset;
    logic         i_valid;
    logic         i_ready;
    logic [19:0]  i_data;
    logic         o_valid;
    logic [179:0] o_data;
    logic         o_done;

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [179:0] data;
        logic         done;
        int           due;
        int           centre;
    } exp_t;

    exp_t         q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           ncyc = 0;
    int           busy_cnt = 0;
    logic [179:0] last_exp = '0;
    logic [179:0] cap [NPIX];

    task automatic check(input string nm, input logic [179:0] act, input logic [179:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [179:0] model_win(input int n);
        logic [179:0] w;
        int r, c, rr, cc;
        w = '0;
        r = n / W;
        c = n % W;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
`ifdef CONV_WIN_REPLICATE_EN
                if (rr < 0) rr = 0;
                if (rr > H - 1) rr = H - 1;
                if (cc < 0) cc = 0;
                if (cc > W - 1) cc = W - 1;
`endif
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    w[(3*dr + dc)*20 +: 20] = 20'(rr*W + cc + 1);
            end
        end
        return w;
    endfunction

    function automatic logic [179:0] pack9(input int v0, input int v1, input int v2,
                                           input int v3, input int v4, input int v5,
                                           input int v6, input int v7, input int v8);
        logic [179:0] w;
        w = {20'(v8), 20'(v7), 20'(v6), 20'(v5), 20'(v4), 20'(v3), 20'(v2), 20'(v1), 20'(v0)};
        return w;
    endfunction

    function automatic void push_exp(input int centre, input int due);
        exp_t e;
        e.data   = model_win(centre);
        e.done   = (centre == NPIX - 1);
        e.due    = due;
        e.centre = centre;
        q.push_back(e);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT strobes a window.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!reset) begin
            last_exp = '0;
        end else if (o_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 180'(o_valid), 180'(0));
            end else begin
                e = q.pop_front();
                check("win_data", o_data, e.data);
                check("win_done", 180'(o_done), 180'(e.done));
                check("win_latency", 180'(ncyc), 180'(e.due));
                last_exp = e.data;
                cap[e.centre] = o_data;
            end
        end else begin
            check("hold_data", o_data, last_exp);
            check("done_idle", 180'(o_done), 180'(0));
        end
        if (reset && !i_ready) busy_cnt++;
    end

    task automatic run_px(input int npx, input bit toggle);
        busy_cnt = 0;
        for (int m = 0; m < npx; m++) begin
            int t;
            t = 0;
            while (!i_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!i_ready) check("ready_timeout", 180'(i_ready), 180'(1));
            i_valid = 1'b1;
            i_data  = 20'(m + 1);
            @(posedge clk);
            if (m >= W + 1) push_exp(m - W - 1, ncyc + 1);
            if (m == NPIX - 1)
                for (int k = 0; k <= W; k++) push_exp(NPIX - W - 1 + k, ncyc + k + 2);
            @(negedge clk);
            i_valid = 1'b0;
            if (toggle) @(negedge clk);
        end
        begin
            int t;
            t = 0;
            while (q.size() != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        check("drain", 180'(q.size()), 180'(0));
        repeat (2) @(negedge clk);
        check("ready_low_cycles", 180'(busy_cnt), 180'((npx == NPIX) ? W + 1 : 0));
    endtask

    task automatic check_reset_outputs();
        check("rst_o_valid", 180'(o_valid), 180'(0));
        check("rst_o_done", 180'(o_done), 180'(0));
        check("rst_o_data", o_data, 180'(0));
        check("rst_i_ready", 180'(i_ready), 180'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_i_ready", 180'(i_ready), 180'(1));

        // Frame 1: continuous valid
        run_px(NPIX, 1'b0);
`ifdef CONV_WIN_REPLICATE_EN
        check("first_window", cap[0], pack9(1, 1, 2, 1, 1, 2, 5, 5, 6));
        check("right_edge_1_3", cap[7], pack9(3, 4, 4, 7, 8, 8, 11, 12, 12));
        check("last_window", cap[15], pack9(11, 12, 12, 15, 16, 16, 15, 16, 16));
`else
        check("first_window", cap[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check("right_edge_1_3", cap[7], pack9(3, 4, 0, 7, 8, 0, 11, 12, 0));
        check("last_window", cap[15], pack9(11, 12, 0, 15, 16, 0, 0, 0, 0));
`endif

        // Frame 2: valid toggling 1-0-1-0
        run_px(NPIX, 1'b1);

        // Partial frame then mid-frame reset
        run_px(7, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        reset = 1'b1;
        @(negedge clk);

        // Full frame after reset must match frame 1
        run_px(NPIX, 1'b0);
`ifdef CONV_WIN_REPLICATE_EN
        check("post_rst_first", cap[0], pack9(1, 1, 2, 1, 1, 2, 5, 5, 6));
`else
        check("post_rst_first", cap[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that sits directly upstream of the convolution kernel stage. It accepts a raster-order pixel stream, buffers two image lines, and emits one zero-padded 3x3 neighbourhood per image pixel as a 180-bit packed window. The window is emitted with a single-cycle valid strobe, in the format the kernel consumes on its `i_valid`/`i_data` inputs. The kernel has no backpressure, so this block never stalls its output.

## Interface
- `IMG_W`, 64, image width in pixels (>= 3)
- `IMG_H`, 64, image height in pixels (>= 3)
- `clk`  input  1  clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low reset (asserted when 0)
- `i_valid`  input  1  input pixel present
- `i_ready`  output  1  block can accept a pixel; a transfer occurs when `i_valid && i_ready` on a rising edge
- `i_data`  input  20  pixel, signed 4.16 fixed point, passed through unmodified
- `o_valid`  output  1  one-cycle strobe: `o_data` holds a complete window
- `o_data`  output  180  window; slot k at bits [k*20 +: 20], k = 3*r + c, r/c = row/col offset +1 from centre (slot 0 top-left, slot 4 centre, slot 8 bottom-right)
- `o_done`  output  1  one-cycle strobe coincident with the last window of a frame

## Operation
- Storage: two line buffers of `IMG_W` x 20 bits; a 3x3 window register; column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1) for the input; output centre counters `ocol`/`orow`.
- States:
  - FILL: accept pixels, no output, until input index `IMG_W` has been accepted.
  - RUN: every accepted pixel after FILL produces exactly one window.
  - FLUSH: entered after the last pixel, index `IMG_W*IMG_H-1`, is accepted. Runs `IMG_W+1` cycles with `i_ready`=0. Each cycle shifts in a virtual zero pixel and emits one window.
  - Leaving FLUSH returns to FILL for the next frame. Counters are cleared on entry to FILL.
- Window emission rule: the window centred on raster index n is emitted one cycle after input index n+`IMG_W`+1 is accepted. If that index is >= `IMG_W*IMG_H`, the window is emitted in the corresponding FLUSH cycle instead. Each frame emits exactly `IMG_W*IMG_H` windows, in raster order of centre.
- Border masking uses `ocol`/`orow`:
  - row offset 0 is zeroed when `orow`=0.
  - row offset 2 is zeroed when `orow`=`IMG_H`-1.
  - col offset 0 is zeroed when `ocol`=0.
  - col offset 2 is zeroed when `ocol`=`IMG_W`-1.
  - Masking is applied before the output register. Wrapped pixels from adjacent rows never leak into a window.
- Input gaps (`i_valid`=0 in FILL/RUN): no state change, no output.
- `i_valid` is ignored in FLUSH.
- Reset asserted mid-frame: all state is discarded immediately. After release the block is in FILL at index 0, and the next accepted pixel is treated as pixel (0,0).

## Timing
- Reset values:
  - `o_valid`=0, `o_done`=0, `o_data`=0.
  - `i_ready`=1 (FILL).
  - Counters 0; line-buffer contents don't-care, because they are masked until written.
- Latency: `o_valid` rises exactly 1 cycle after the accepting edge of the triggering pixel.
- `o_data`, `o_valid`, `o_done` are registered outputs. `o_data` holds its last value while `o_valid`=0.
- `i_ready` is a registered/state-decoded output. It drops in the cycle after the last pixel of a frame is accepted and rises again in the cycle after the final FLUSH window.
- Sustained throughput: 1 window per cycle in RUN and in FLUSH.
- Frame turnaround: `IMG_W+1` cycles of `i_ready`=0 between frames.

## Configuration
- `CONV_WIN_REPLICATE_EN`:
  - Defined: out-of-image taps take the nearest in-image pixel instead of zero. Row/column coordinates are clamped, and corners clamp on both axes.
  - Undefined: out-of-image taps are 20'h00000 (zero padding). This is the default build.
- The macro affects the masking mux only; timing, counts and handshake are identical in both builds.

## Test plan
- `IMG_W`=`IMG_H`=4, pixel value = index+1, `i_valid` held high -> first `o_valid` 1 cycle after index 5 is accepted.
  - Slots 4=1, 5=2, 7=5, 8=6; all other slots 0.
  - 16 windows total, contiguous; `o_done` is set on the 16th.
- Same frame: last window (centre (3,3)) -> slots 0=11, 1=12, 3=15, 4=16, rest 0.
  - Emitted on the 5th FLUSH cycle; `i_ready`=0 for exactly 5 cycles.
- Same frame with `i_valid` toggling 1-0-1-0 -> same 16 windows in the same order, each 1 cycle after its trigger pixel; no `o_valid` during gaps.
- Right-edge check: window centred (1,3) -> slots 2, 5, 8 = 0; slot 0=3, slot 4=8, slot 6=11, slot 7=12. No value from column 0 of the next row may appear.
- Reset pulled low after 7 pixels, then released and a full frame sent -> outputs all 0 during reset; post-release output is bit-identical to the first scenario.
- `CONV_WIN_REPLICATE_EN` defined, first scenario -> first window slots 0=1, 1=1, 2=2, 3=1, 4=1, 5=2, 6=5, 7=5, 8=6.
